featuremap_layer_sequencer: RTL and testbench

- Sequences one convolution layer built from featuremap_conv2d filter blocks: one common read strobe for all CHANNELS input FIFOs, which also drives every conv2D valid_in.
- Reads exactly one padded frame of (WIDTH+2)x(HEIGHT+2) pixels per channel and counts the filter's WIDTH*HEIGHT output pixels.
- Signals layer completion, and flags timeout or count errors to the layer-level top.

---
 rtl/featuremap_layer_sequencer.sv | 75 +++++++
 tb/tb_featuremap_layer_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/featuremap_layer_sequencer.sv
// featuremap_layer_sequencer: lockstep reads of one padded frame across all channel FIFOs and output-pixel accounting
module featuremap_layer_sequencer #(
  parameter int CHANNELS = 16,
  parameter int WIDTH = 56,
  parameter int HEIGHT = 56,
  parameter int TIMEOUT = 1024,
  localparam int CW = $clog2(WIDTH + 2),
  localparam int RW = $clog2(HEIGHT + 2),
  localparam int OW = $clog2(WIDTH * HEIGHT + 1),
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CHANNELS-1:0] fifo_empty,
  input  logic                out_afull,
  input  logic                conv_valid_out,
  output logic                rd_en,
  output logic                busy,
  output logic                done,
  output logic                err_timeout,
  output logic                err_count,
  output logic [CW-1:0]       in_col,
  output logic [RW-1:0]       in_row,
  output logic [OW-1:0]       out_count
);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH + 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT + 1);
  localparam logic [OW-1:0] OUT_FULL = OW'(WIDTH * HEIGHT);
  localparam logic [OW-1:0] OUT_PRE = OW'(WIDTH * HEIGHT - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [TW-1:0] tmo;
  logic col_end, frame_end, full, tmo_hit;
  always_comb begin
    rd_en = state == RUN && !(|fifo_empty) && !out_afull;
    busy = state == RUN || state == DRAIN;
    done = state == DONE;
    col_end = in_col == COL_LAST;
    frame_end = rd_en && col_end && in_row == ROW_LAST;
    full = out_count == OUT_FULL;
    tmo_hit = !conv_valid_out && tmo == TMO_LAST;
    state_nx = state == IDLE  ? (start ? RUN : IDLE) :
               state == RUN   ? (frame_end ? DRAIN : RUN) :
               state == DRAIN ? (full ? DONE : tmo_hit ? IDLE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      in_col <= '0;
      in_row <= '0;
      out_count <= '0;
      tmo <= '0;
      err_timeout <= 1'b0;
      err_count <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        in_col <= '0;
        in_row <= '0;
        out_count <= '0;
        tmo <= '0;
      end else if (rd_en) begin
        in_col <= col_end ? '0 : in_col + 1'b1;
        in_row <= frame_end ? '0 : col_end ? in_row + 1'b1 : in_row;
      end
      if (busy && conv_valid_out && !full) out_count <= out_count + 1'b1;
      if (state == DRAIN) tmo <= conv_valid_out ? '0 : tmo + 1'b1;
      // a valid outside a frame, past a full count, or completing the count before reads finish is an accounting error
      if (conv_valid_out && (!busy || full || (state == RUN && out_count == OUT_PRE))) err_count <= 1'b1;
      if (state == DRAIN && !full && tmo_hit) err_timeout <= 1'b1;
    end
endmodule

// File: tb/tb_featuremap_layer_sequencer.sv
// tb_featuremap_layer_sequencer: randomized frames checked every cycle against a frame-level behavioural model
module tb_featuremap_layer_sequencer;
  localparam int CH = 16, W = 4, H = 4, TO = 8, WH = W * H, NR = (W + 2) * (H + 2);
  logic clk = 0, rst = 1, start = 0, out_afull = 0, conv_valid_out = 0;
  logic [CH-1:0] fifo_empty = '0;
  logic rd_en, busy, done, err_timeout, err_count;
  logic [2:0] in_col, in_row;
  logic [4:0] out_count;
  int checks = 0, errors = 0;
  int ph = 0, reads = 0, oc = 0, tmo = 0, m_to = 0, m_cnt = 0;
  int cyc = 0, n_rd = 0, n_done = 0, n_low = 0, wraps = 0, prev_col = 0;
  int last_v = 0, to_cyc = 0, seen_to = 0;
  always #5 clk = ~clk;
  featuremap_layer_sequencer #(.CHANNELS(CH), .WIDTH(W), .HEIGHT(H), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .fifo_empty(fifo_empty), .out_afull(out_afull),
    .conv_valid_out(conv_valid_out), .rd_en(rd_en), .busy(busy), .done(done),
    .err_timeout(err_timeout), .err_count(err_count), .in_col(in_col), .in_row(in_row),
    .out_count(out_count));
  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // phase: 0 idle, 1 reading, 2 draining, 3 done; reads is the linear pixel index of the frame
  task automatic update(input bit rd);
    int oc0 = oc;
    if (conv_valid_out) begin
      if (ph == 1 || ph == 2) begin
        if (oc == WH) m_cnt = 1;
        else begin
          oc++;
          if (oc == WH && ph == 1) m_cnt = 1;
        end
      end else m_cnt = 1;
    end
    case (ph)
      0: if (start) begin reads = 0; oc = 0; tmo = 0; ph = 1; end
      1: if (rd) begin reads++; if (reads == NR) begin reads = 0; ph = 2; end end
      2: if (oc0 == WH) ph = 3;
         else if (conv_valid_out) tmo = 0;
         else begin tmo++; if (tmo == TO) begin m_to = 1; ph = 0; end end
      default: ph = 0;
    endcase
  endtask
  task automatic step();
    bit rd;
    #1;
    rd = ph == 1 && fifo_empty == '0 && !out_afull;
    chk("rd_en", rd_en, int'(rd));
    chk("busy", busy, int'(ph == 1 || ph == 2));
    chk("done", done, int'(ph == 3));
    chk("err_timeout", err_timeout, m_to);
    chk("err_count", err_count, m_cnt);
    chk("in_col", in_col, reads % (W + 2));
    chk("in_row", in_row, reads / (W + 2));
    chk("out_count", out_count, oc);
    n_rd += int'(rd_en);
    n_done += int'(done);
    if (ph == 1 && !rd_en) n_low++;
    if (prev_col == 5 && in_col == 0) wraps++;
    prev_col = int'(in_col);
    if (conv_valid_out) last_v = cyc;
    if (err_timeout && seen_to == 0) begin seen_to = 1; to_cyc = cyc; end
    @(posedge clk);
    update(rd);
    @(negedge clk);
    cyc++;
  endtask
  task automatic do_reset();
    start = 0; conv_valid_out = 0; fifo_empty = '0; out_afull = 0;
    rst = 0;
    #1;
    ph = 0; reads = 0; oc = 0; tmo = 0; m_to = 0; m_cnt = 0; prev_col = 0;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_errs", {err_timeout, err_count}, 0);
    chk("rst_col_row", {in_col, in_row}, 0);
    chk("rst_out_count", out_count, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
  endtask
  // kind: 0 none, 1 fifo_empty[7] stall, 2 out_afull stall; nv valids returned in total
  task automatic frame(input int kind, input int s_at, input int s_len, input int nv, input bit run_v, input bit rnd);
    int budget = 0, stall = 0, sent = 0, gap = 0;
    bit fired = 0;
    n_rd = 0; n_done = 0; n_low = 0; wraps = 0;
    start = 1;
    step();
    start = 0;
    while (ph != 0 && budget < 600) begin
      fifo_empty = '0; out_afull = 0; conv_valid_out = 0;
      if (kind != 0 && ph == 1 && reads == s_at && !fired) begin stall = s_len; fired = 1; end
      if (stall > 0) begin
        if (kind == 1) fifo_empty[7] = 1'b1; else out_afull = 1'b1;
        stall--;
      end
      if (rnd && $urandom_range(0, 7) == 0) fifo_empty[$urandom_range(0, CH - 1)] = 1'b1;
      if (rnd && $urandom_range(0, 7) == 0) out_afull = 1'b1;
      start = rnd && $urandom_range(0, 4) == 0;
      if ((ph == 2 || ph == 3) && sent < nv && (sent >= WH || gap >= 4 || $urandom_range(0, 3) != 0))
        conv_valid_out = 1'b1;
      else if (ph == 1 && run_v && sent < WH - 1 && reads > W && $urandom_range(0, 3) == 0)
        conv_valid_out = 1'b1;
      if (conv_valid_out) begin sent++; gap = 0; end
      else if (ph == 2) gap++;
      step();
      budget++;
    end
    fifo_empty = '0; out_afull = 0; conv_valid_out = 0; start = 0;
    if (budget >= 600) begin
      checks++; errors++;
      $display("FAIL frame_budget phase %0d expected 0", ph);
    end
  endtask
  initial begin
    int b;
    #2;
    do_reset();
    step();
    frame(0, 0, 0, WH, 0, 0);
    chk("f1_reads", n_rd, 36);
    chk("f1_done", n_done, 1);
    chk("f1_wraps", wraps, 6);
    chk("f1_busy", busy, 0);
    chk("f1_count", out_count, 16);
    chk("f1_errs", {err_timeout, err_count}, 0);
    frame(1, 10, 5, WH, 0, 0);
    chk("f2_reads", n_rd, 36);
    chk("f2_stall", n_low, 5);
    chk("f2_done", n_done, 1);
    frame(2, 15, 20, WH, 0, 0);
    chk("f3_reads", n_rd, 36);
    chk("f3_stall", n_low, 20);
    chk("f3_done", n_done, 1);
    repeat (6) begin
      frame(0, 0, 0, WH, 1, 1);
      chk("rnd_reads", n_rd, 36);
      chk("rnd_done", n_done, 1);
      chk("rnd_err_count", err_count, 0);
    end
    frame(0, 0, 0, WH + 1, 0, 0);
    chk("ovf_count", out_count, 16);
    chk("ovf_err", err_count, 1);
    chk("ovf_done", n_done, 1);
    conv_valid_out = 1;
    step();
    conv_valid_out = 0;
    step();
    chk("idle_valid_count", out_count, 16);
    chk("idle_valid_err", err_count, 1);
    seen_to = 0;
    frame(0, 0, 0, WH - 1, 0, 0);
    repeat (2) step();
    chk("to_err", err_timeout, 1);
    chk("to_delay", to_cyc - last_v, TO + 1);
    chk("to_done", n_done, 0);
    chk("to_busy", busy, 0);
    start = 1;
    step();
    start = 0;
    b = 0;
    while (reads < 20 && b < 100) begin step(); b++; end
    chk("mid_reads", reads, 20);
    do_reset();
    repeat (2) step();
    frame(0, 0, 0, WH, 0, 1);
    chk("rr_reads", n_rd, 36);
    chk("rr_done", n_done, 1);
    chk("rr_errs", {err_timeout, err_count}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
